fft_acc_pingpong_ram: RTL
=========================

Name: fft_acc_pingpong_ram

Overview:
Parametrised two-bank (ping-pong) on-chip sample buffer for the FFT accelerator. Host port s1 is an Avalon-MM slave with byte enables. Engine port e is a word-wide port used by the FFT datapath. Each port always owns the opposite bank; a handshaked swap exchanges them, so the host fills frame N+1 while the engine processes frame N.

Parameters:
DATA_W, 32, word width in bits; multiple of 8
ADDR_W, 10, word address width per bank; depth per bank = 2**ADDR_W
RD_LAT, 1, read latency in cycles, from accepted read to readdatavalid; legal 1..3

Ports:
clk  in  1  single clock
reset  in  1  asynchronous active-high reset
clken  in  1  global clock enable; 0 = whole block holds state
reset_req  in  1  reset-request guard; effective enable = clken & ~reset_req
s1_address  in  ADDR_W  host word address within host bank
s1_chipselect  in  1  host access qualifier
s1_read  in  1  host read strobe
s1_write  in  1  host write strobe
s1_byteenable  in  DATA_W/8  host write byte lanes
s1_writedata  in  DATA_W  host write data
s1_readdata  out  DATA_W  host read data
s1_readdatavalid  out  1  one-cycle pulse per completed host read
s1_waitrequest  out  1  host access stalled (swap in progress)
e_address  in  ADDR_W  engine word address within engine bank
e_read  in  1  engine read strobe
e_write  in  1  engine write strobe, full word
e_writedata  in  DATA_W  engine write data
e_readdata  out  DATA_W  engine read data
e_readdatavalid  out  1  one-cycle pulse per completed engine read
e_waitrequest  out  1  engine access stalled (swap in progress)
swap_req  in  1  request bank exchange, sampled when enabled
swap_ack  out  1  one-cycle pulse when exchange completes
host_bank  out  1  bank currently owned by host; engine owns ~host_bank

Behaviour:
- Reset values: host_bank=0, FSM=IDLE, swap_ack=0, both readdatavalid=0, both readdata=0, both waitrequest=0. Memory contents are not cleared.
- Enable: when clken & ~reset_req is 0, all registers, RAM writes, read pipelines and the FSM hold. Outputs keep their values; pulses do not repeat.
- Access acceptance: a host access is accepted when s1_chipselect=1 and s1_waitrequest=0. An engine access is accepted when (e_read|e_write)=1 and e_waitrequest=0.
- Writes: take effect on the accepting edge. Host writes only the lanes set in s1_byteenable.
- Reads: data and valid appear exactly RD_LAT enabled cycles after acceptance. Reads are fully pipelined, one per cycle per port.
- Read and write in the same cycle on one port: the write is performed and the read is dropped (no valid).
- The two ports never touch the same bank, so no collision rule is needed.
- FSM states:
  - IDLE: if swap_req=1, go to DRAIN. An access presented in that same cycle is still accepted.
  - DRAIN: both waitrequests=1. Count RD_LAT cycles so in-flight reads complete from the old banks, then go to SWAP.
  - SWAP: both waitrequests=1; toggle host_bank; swap_ack=1 for this cycle; go to IDLE.
- swap_req asserted during DRAIN or SWAP is ignored (not queued).
- Async reset mid-swap: aborts the swap, host_bank returns to 0, and in-flight reads are discarded with no valid.

Optional Feature:
FFT_ACC_PP_BITREV_EN: adds input e_bitrev (1 bit). When e_bitrev=1, e_address is bit-reversed over ADDR_W bits before addressing, giving radix-2 input reordering. Without the macro the port is absent and e_address is used directly. Host addressing is unaffected in both cases.

Test Plan:
(ADDR_W=10, RD_LAT=2, DATA_W=32.)
- Host write 0xDEADBEEF to addr 5 with byteenable=4'b0101, then read addr 5 -> readdatavalid two cycles after the read; data = 0x00AD00EF over zero-initialised RAM.
- Host writes 0x11 to addr 3 (bank 0); swap_req pulse -> waitrequests high for 3 cycles; swap_ack pulses; host_bank=1; engine read addr 3 returns 0x11.
- Host read accepted in the same cycle as swap_req -> its valid arrives during DRAIN with pre-swap bank data.
- clken=0 for 4 cycles between an accepted read and its valid -> valid is delayed exactly 4 cycles; data is unchanged.
- Assert reset during DRAIN -> host_bank=0, no swap_ack, no pending valid; RAM data retained.
- With FFT_ACC_PP_BITREV_EN: engine write addr 1 with e_bitrev=1 -> host reads the value at physical addr 512 after a swap.

Source files
------------

// File: rtl/fft_acc_pingpong_ram_if.sv
// fft_acc_pingpong_ram_if: host Avalon-MM, engine word port and swap handshake for the ping-pong buffer.
// e_bitrev exists only when FFT_ACC_PP_BITREV_EN is defined.
interface fft_acc_pingpong_ram_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0]   s1_address;
  logic                s1_chipselect;
  logic                s1_read;
  logic                s1_write;
  logic [DATA_W/8-1:0] s1_byteenable;
  logic [DATA_W-1:0]   s1_writedata;
  logic [DATA_W-1:0]   s1_readdata;
  logic                s1_readdatavalid;
  logic                s1_waitrequest;
  logic [ADDR_W-1:0]   e_address;
  logic                e_read;
  logic                e_write;
  logic [DATA_W-1:0]   e_writedata;
  logic [DATA_W-1:0]   e_readdata;
  logic                e_readdatavalid;
  logic                e_waitrequest;
`ifdef FFT_ACC_PP_BITREV_EN
  logic                e_bitrev;
`endif
  logic                swap_req;
  logic                swap_ack;
  logic                host_bank;
  modport slave (
`ifdef FFT_ACC_PP_BITREV_EN
    input e_bitrev,
`endif
    input s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
    output s1_readdata, s1_readdatavalid, s1_waitrequest,
    input e_address, e_read, e_write, e_writedata,
    output e_readdata, e_readdatavalid, e_waitrequest,
    input swap_req,
    output swap_ack, host_bank
  );
  modport master (
`ifdef FFT_ACC_PP_BITREV_EN
    output e_bitrev,
`endif
    output s1_address, s1_chipselect, s1_read, s1_write, s1_byteenable, s1_writedata,
    input s1_readdata, s1_readdatavalid, s1_waitrequest,
    output e_address, e_read, e_write, e_writedata,
    input e_readdata, e_readdatavalid, e_waitrequest,
    output swap_req,
    input swap_ack, host_bank
  );
endinterface

// File: rtl/fft_acc_pingpong_ram.sv
// fft_acc_pingpong_ram: two-bank sample buffer, host and engine own opposite banks, handshaked swap.
// Define FFT_ACC_PP_BITREV_EN to add e_bitrev (bit-reversed engine addressing).
module fft_acc_pingpong_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic reset,
  input logic clken,
  input logic reset_req,
  fft_acc_pingpong_ram_if.slave bus
);
  localparam int NB = DATA_W / 8;
  typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;
  state_t state;
  logic [1:0] cnt;
  logic stall, ack, hb;
  logic en, h_acc, h_wr, h_rd, e_wr, e_rd;
  logic [ADDR_W-1:0] ea;
  logic [DATA_W-1:0] mem [2][2**ADDR_W];
  logic [DATA_W-1:0] h_data [RD_LAT];
  logic [DATA_W-1:0] e_data [RD_LAT];
  logic [RD_LAT-1:0] h_vld, e_vld;
`ifdef FFT_ACC_PP_BITREV_EN
  always_comb begin
    ea = bus.e_address;
    for (int i = 0; i < ADDR_W; i++)
      ea[i] = bus.e_bitrev ? bus.e_address[ADDR_W-1-i] : bus.e_address[i];
  end
`else
  assign ea = bus.e_address;
`endif
  assign en    = clken & ~reset_req;
  assign h_acc = en & bus.s1_chipselect & ~stall;
  assign h_wr  = h_acc & bus.s1_write;
  assign h_rd  = h_acc & bus.s1_read & ~bus.s1_write;
  assign e_wr  = en & ~stall & bus.e_write;
  assign e_rd  = en & ~stall & bus.e_read & ~bus.e_write;
  // Memory has no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++)
      if (h_wr && bus.s1_byteenable[b])
        mem[hb][bus.s1_address][8*b +: 8] <= bus.s1_writedata[8*b +: 8];
    if (e_wr)
      mem[~hb][ea] <= bus.e_writedata;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_vld <= '0;
      e_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        h_data[i] <= '0;
        e_data[i] <= '0;
      end
    end else if (en) begin
      h_vld[0]  <= h_rd;
      e_vld[0]  <= e_rd;
      h_data[0] <= h_rd ? mem[hb][bus.s1_address] : h_data[0];
      e_data[0] <= e_rd ? mem[~hb][ea] : e_data[0];
      for (int i = 1; i < RD_LAT; i++) begin
        h_vld[i]  <= h_vld[i-1];
        e_vld[i]  <= e_vld[i-1];
        h_data[i] <= h_data[i-1];
        e_data[i] <= e_data[i-1];
      end
    end
  end
  // DRAIN lasts RD_LAT cycles so reads accepted before the swap finish on the old banks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      stall <= 1'b0;
      ack   <= 1'b0;
      hb    <= 1'b0;
    end else if (en) begin
      case (state)
        IDLE: if (bus.swap_req) begin
          state <= DRAIN;
          cnt   <= '0;
          stall <= 1'b1;
        end
        DRAIN: if (cnt == 2'(RD_LAT - 1)) begin
          state <= SWAP;
          ack   <= 1'b1;
          hb    <= ~hb;
        end else cnt <= cnt + 2'd1;
        SWAP: begin
          state <= IDLE;
          ack   <= 1'b0;
          stall <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.s1_readdata      = h_data[RD_LAT-1];
  assign bus.s1_readdatavalid = h_vld[RD_LAT-1];
  assign bus.s1_waitrequest   = stall;
  assign bus.e_readdata       = e_data[RD_LAT-1];
  assign bus.e_readdatavalid  = e_vld[RD_LAT-1];
  assign bus.e_waitrequest    = stall;
  assign bus.swap_ack         = ack;
  assign bus.host_bank        = hb;
endmodule
